bit_unpacking_stream: RTL and testbench
=======================================

# bit_unpacking_stream

Streaming bit unpacker for the binary-image path. It accepts packed bytes, 8 binary pixels per byte with pixel 0 in bit 0. It emits one thresholded pixel per cycle as a 1-bit value plus an 8-bit grey-level expansion. It sits downstream of the bit-packing stage (memory/UART readback) and feeds display, or the comparison against the original thresholded frame.

## Interface
- FRAME_PIXELS, 64: pixels per frame (≥1); need not be a multiple of 8.
- FG_VALUE, 8'hFF: grey value emitted for pixel=1.
- BG_VALUE, 8'h00: grey value emitted for pixel=0.
- CNT_W, $clog2(FRAME_PIXELS): pixel index width, derived, not overridden.
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame from IDLE or DONE.
- byte_in  in  8  packed pixel byte, bit 0 = earliest pixel.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  unpacker can take a byte this cycle.
- pixel_out  out  1  current binary pixel.
- pixel_gray  out  8  FG_VALUE if pixel_out else BG_VALUE.
- pixel_valid  out  1  pixel_out/pixel_gray/pixel_index/pixel_last valid.
- pixel_ready  in  1  consumer accepts the pixel.
- pixel_last  out  1  current pixel is index FRAME_PIXELS-1.
- pixel_index  out  CNT_W  index of current pixel within the frame.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last pixel handshake.

## Operation
- States:
  - IDLE →(start) RUN.
  - RUN →(handshake on last pixel) DONE.
  - DONE →(start) RUN.
  - start in RUN is ignored.
- Internal storage:
  - sreg[7:0] is a shift register.
  - bit_ptr[2:0] is the bit position within the byte.
  - have flags a byte held.
  - pix_cnt[CNT_W-1:0] counts pixels in the frame.
- Byte acceptance:
  - Accept a byte when byte_valid && byte_ready.
  - byte_ready = RUN && (!have || (pixel handshake && bit_ptr==7 && !pixel_last)).
  - byte_ready is 0 in IDLE and DONE; bytes offered there are not consumed.
  - On accept: sreg←byte_in, bit_ptr←0, have←1.
- Pixel output:
  - pixel_valid = RUN && have.
  - pixel_out = sreg[0]; pixel_index = pix_cnt; pixel_last = (pix_cnt==FRAME_PIXELS-1).
  - All outputs are driven from registers, with no combinational path from byte_in.
- Pixel handshake (pixel_valid && pixel_ready):
  - sreg shifts right, bit_ptr++, pix_cnt++.
  - If bit_ptr==7 and no byte is accepted in the same cycle, have←0.
- Last pixel handshake:
  - have←0, pix_cnt←0, state←DONE, done=1 for exactly one cycle.
  - Unused high bits of a partial final byte are discarded.
- Backpressure: while pixel_valid && !pixel_ready, all pixel outputs hold stable. pixel_valid never drops without a handshake.
- start from DONE clears pix_cnt and have; the next frame starts at index 0.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=IDLE, sreg=0, bit_ptr=0, have=0, pix_cnt=0.
  - Outputs: byte_ready=0, pixel_valid=0, pixel_out=0, pixel_gray=BG_VALUE, pixel_last=0, pixel_index=0, busy=0, done=0.
- Reset mid-frame aborts the frame and discards the held byte; done is not pulsed.
- start at edge k: busy=1 and byte_ready=1 after edge k.
- Byte accepted at edge k: pixel 0 of that byte is valid after edge k, so latency is 1 cycle.
- Sustained throughput is 1 pixel/cycle. The next byte is accepted on the same edge as the bit-7 handshake, leaving no bubble when byte_valid is held.
- Last pixel handshake at edge k: done=1 and busy=0 during cycle k+1 only.

## Structure
- Shared package `bitpack_pkg`:
  - state enum {IDLE, RUN, DONE};
  - PIXELS_PER_BYTE=8;
  - default FG/BG constants;
  - both used by the packer too.
- No sub-module needed. Optional `unpack_shift_reg` (sreg + bit_ptr + have) is acceptable if it keeps the FSM readable.

## Test plan
- FRAME_PIXELS=16, start, bytes 0xA5, 0x3C, pixel_ready=1:
  - pixels 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, with no gaps;
  - pixel_last on index 15 only;
  - done pulse 1 cycle later; exactly 2 byte handshakes.
- Same frame, pixel_ready toggled pseudo-randomly:
  - identical sequence;
  - outputs stable across every stall cycle;
  - byte_ready only asserted with the bit-7 handshake or when empty.
- FRAME_PIXELS=12, bytes 0xFF, 0x0F:
  - 12 ones, pixel_gray=8'hFF throughout;
  - last at index 11; byte_ready=0 after the second byte.
- Reset pulse after 5 pixel handshakes:
  - all outputs at reset values immediately (asynchronous);
  - no done pulse;
  - after reset_n high and start, byte 0x01 gives index 0, pixel 1.
- Protocol guards:
  - byte_valid=1 in IDLE → byte_ready=0, nothing accepted;
  - start while busy → no restart; index continues;
  - start in DONE → new frame from index 0.
- Round trip: a random 64-pixel binary frame through the bit-packing stage and this block reproduces the original pixel sequence exactly.

Source files
------------

// File: rtl/bitpack_pkg.sv
// Shared definitions for the binary-image bit packing and unpacking stages.
package bitpack_pkg;

    localparam int         PIXELS_PER_BYTE = 8;
    localparam logic [7:0] FG_DEFAULT      = 8'hFF;
    localparam logic [7:0] BG_DEFAULT      = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width that stays legal for single-pixel frames.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_unpacking_stream.sv
// Streaming unpacker: packed bytes (pixel 0 in bit 0) in, one thresholded pixel
// per cycle out with an 8-bit grey-level expansion.
module bit_unpacking_stream
    import bitpack_pkg::*;
#(
    parameter int         FRAME_PIXELS = 64,
    parameter logic [7:0] FG_VALUE     = FG_DEFAULT,
    parameter logic [7:0] BG_VALUE     = BG_DEFAULT,
    localparam int        CNT_W        = cnt_width(FRAME_PIXELS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             pixel_out,
    output logic [7:0]       pixel_gray,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic             pixel_last,
    output logic [CNT_W-1:0] pixel_index,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [2:0]       LAST_BIT = 3'(PIXELS_PER_BYTE - 1);

    state_t           state_reg, state_next;
    logic [7:0]       sreg_reg;
    logic [2:0]       bit_ptr_reg;
    logic             have_reg;
    logic [CNT_W-1:0] pix_cnt_reg;
    logic             done_reg;

    logic running, at_last, pixel_hs, byte_hs, start_frame;

    assign running     = (state_reg == RUN);
    assign at_last     = (pix_cnt_reg == LAST_IDX);
    assign pixel_valid = running && have_reg;
    assign pixel_hs    = pixel_valid && pixel_ready;
    // Refill on the same edge as the bit-7 handshake so a held byte_valid sees no bubble.
    assign byte_ready  = running && (!have_reg ||
                         (pixel_hs && (bit_ptr_reg == LAST_BIT) && !at_last));
    assign byte_hs     = byte_valid && byte_ready;
    assign start_frame = start && !running;

    assign pixel_out   = sreg_reg[0];
    assign pixel_gray  = sreg_reg[0] ? FG_VALUE : BG_VALUE;
    assign pixel_last  = pixel_valid && at_last;
    assign pixel_index = pix_cnt_reg;
    assign busy        = running;
    assign done        = done_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (pixel_hs && at_last) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_reg    <= 8'h00;
            bit_ptr_reg <= 3'd0;
            have_reg    <= 1'b0;
            pix_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start_frame) begin
                have_reg    <= 1'b0;
                bit_ptr_reg <= 3'd0;
                pix_cnt_reg <= '0;
            end else if (running) begin
                if (byte_hs) begin
                    sreg_reg    <= byte_in;
                    bit_ptr_reg <= 3'd0;
                    have_reg    <= 1'b1;
                end else if (pixel_hs) begin
                    sreg_reg    <= {1'b0, sreg_reg[7:1]};
                    bit_ptr_reg <= bit_ptr_reg + 3'd1;
                    // Last pixel also drops the byte: unused high bits of a partial byte are discarded.
                    if ((bit_ptr_reg == LAST_BIT) || at_last) begin
                        have_reg <= 1'b0;
                    end
                end
                if (pixel_hs) begin
                    if (at_last) begin
                        pix_cnt_reg <= '0;
                        done_reg    <= 1'b1;
                    end else begin
                        pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_unpacking_stream.sv
// Self-checking bench for bit_unpacking_stream: three frame sizes behind one muxed view.
module tb_bit_unpacking_stream;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       pixel_ready;
    int         sel;

    always #5 clk = ~clk;

    logic       br0, po0, pv0, pl0, by0, dn0;
    logic [7:0] pg0;
    logic [3:0] pi0;
    logic       br1, po1, pv1, pl1, by1, dn1;
    logic [7:0] pg1;
    logic [3:0] pi1;
    logic       br2, po2, pv2, pl2, by2, dn2;
    logic [7:0] pg2;
    logic [5:0] pi2;

    bit_unpacking_stream #(.FRAME_PIXELS(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start && sel == 0), .byte_in(byte_in),
        .byte_valid(byte_valid && sel == 0), .byte_ready(br0), .pixel_out(po0),
        .pixel_gray(pg0), .pixel_valid(pv0), .pixel_ready(pixel_ready), .pixel_last(pl0),
        .pixel_index(pi0), .busy(by0), .done(dn0));

    bit_unpacking_stream #(.FRAME_PIXELS(12)) dut12 (
        .clk(clk), .reset_n(reset_n), .start(start && sel == 1), .byte_in(byte_in),
        .byte_valid(byte_valid && sel == 1), .byte_ready(br1), .pixel_out(po1),
        .pixel_gray(pg1), .pixel_valid(pv1), .pixel_ready(pixel_ready), .pixel_last(pl1),
        .pixel_index(pi1), .busy(by1), .done(dn1));

    bit_unpacking_stream #(.FRAME_PIXELS(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start && sel == 2), .byte_in(byte_in),
        .byte_valid(byte_valid && sel == 2), .byte_ready(br2), .pixel_out(po2),
        .pixel_gray(pg2), .pixel_valid(pv2), .pixel_ready(pixel_ready), .pixel_last(pl2),
        .pixel_index(pi2), .busy(by2), .done(dn2));

    logic       m_br, m_po, m_pv, m_pl, m_busy, m_done;
    logic [7:0] m_pg;
    int         m_pi;

    always_comb begin
        m_br = br2; m_po = po2; m_pv = pv2; m_pl = pl2; m_busy = by2; m_done = dn2;
        m_pg = pg2; m_pi = int'(pi2);
        case (sel)
            0: begin
                m_br = br0; m_po = po0; m_pv = pv0; m_pl = pl0; m_busy = by0; m_done = dn0;
                m_pg = pg0; m_pi = int'(pi0);
            end
            1: begin
                m_br = br1; m_po = po1; m_pv = pv1; m_pl = pl1; m_busy = by1; m_done = dn1;
                m_pg = pg1; m_pi = int'(pi1);
            end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".byte_ready"}, m_br, 0);
        chk({tag, ".pixel_valid"}, m_pv, 0);
        chk({tag, ".pixel_out"}, m_po, 0);
        chk({tag, ".pixel_gray"}, m_pg, 8'h00);
        chk({tag, ".pixel_last"}, m_pl, 0);
        chk({tag, ".pixel_index"}, m_pi, 0);
        chk({tag, ".busy"}, m_busy, 0);
        chk({tag, ".done"}, m_done, 0);
    endtask

    // Runs one frame; expectations come from the reference pixel list and byte/pixel counts.
    task automatic run_frame(input int s, input int npix, input logic [7:0] bq[$],
                             input bit ep[$], input bit rnd, input string name);
        int       acc, done_px, cycles, obs_bytes, obs_pix;
        bit       held, hs_e, exp_br, prev_stall;
        logic     sv_po, sv_pl;
        logic [7:0] sv_pg;
        int       sv_pi;
        acc = 0; done_px = 0; cycles = 0; obs_bytes = 0; obs_pix = 0; prev_stall = 0;
        sv_po = 0; sv_pl = 0; sv_pg = 0; sv_pi = 0;
        @(negedge clk);
        sel = s; start = 1'b1; byte_valid = 1'b0; pixel_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (done_px < npix && cycles < 2000) begin
            byte_in     = (acc < bq.size()) ? bq[acc] : 8'hEE;
            byte_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pixel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start       = rnd && ($urandom_range(0, 9) == 0);
            #1;
            held   = (acc * 8) > done_px;
            hs_e   = held && pixel_ready;
            exp_br = !held || (hs_e && (done_px % 8 == 7) && (done_px != npix - 1));
            chk({name, ".busy"}, m_busy, 1);
            chk({name, ".pixel_valid"}, m_pv, held);
            chk({name, ".byte_ready"}, m_br, exp_br);
            chk({name, ".done_early"}, m_done, 0);
            if (held) begin
                chk({name, ".pixel_out"}, m_po, ep[done_px]);
                chk({name, ".pixel_gray"}, m_pg, ep[done_px] ? 8'hFF : 8'h00);
                chk({name, ".pixel_index"}, m_pi, done_px);
                chk({name, ".pixel_last"}, m_pl, done_px == npix - 1);
            end
            if (prev_stall) begin
                chk({name, ".stall_out"}, m_po, sv_po);
                chk({name, ".stall_gray"}, m_pg, sv_pg);
                chk({name, ".stall_index"}, m_pi, sv_pi);
                chk({name, ".stall_last"}, m_pl, sv_pl);
            end
            prev_stall = held && !pixel_ready;
            sv_po = m_po; sv_pg = m_pg; sv_pi = m_pi; sv_pl = m_pl;
            if (m_br && byte_valid) obs_bytes++;
            if (m_pv && pixel_ready) obs_pix++;
            $display("%s cyc=%0d idx=%0d valid=%0b ready=%0b pix=%0b br=%0b bv=%0b",
                     name, cycles, m_pi, m_pv, pixel_ready, m_po, m_br, byte_valid);
            @(posedge clk);
            if (exp_br && byte_valid) acc++;
            if (hs_e) done_px++;
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 2000) chk({name, ".timeout"}, 0, 1);
        start = 1'b0; byte_valid = 1'b1; byte_in = 8'hEE; pixel_ready = 1'b1;
        #1;
        chk({name, ".done_pulse"}, m_done, 1);
        chk({name, ".busy_after"}, m_busy, 0);
        chk({name, ".br_after"}, m_br, 0);
        chk({name, ".pv_after"}, m_pv, 0);
        chk({name, ".byte_count"}, obs_bytes, (npix + 7) / 8);
        chk({name, ".pixel_count"}, obs_pix, npix);
        @(negedge clk);
        #1;
        chk({name, ".done_one_cycle"}, m_done, 0);
        chk({name, ".br_done"}, m_br, 0);
        byte_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] bq[$];
        bit         ep[$];
        bit         pix[64];
        logic [7:0] b;
        int         hs_cnt, guard;

        reset_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        pixel_ready = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset("reset");
        reset_n = 1'b1;

        // Bytes offered in IDLE must not be taken.
        byte_valid = 1'b1; byte_in = 8'h77;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle.byte_ready", m_br, 0);
            chk("idle.pixel_valid", m_pv, 0);
            chk("idle.busy", m_busy, 0);
        end
        byte_valid = 1'b0;

        bq = {8'hA5, 8'h3C};
        ep = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        run_frame(0, 16, bq, ep, 1'b0, "f16");
        run_frame(0, 16, bq, ep, 1'b1, "f16stall");

        bq = {8'hFF, 8'h0F};
        ep.delete();
        for (int i = 0; i < 12; i++) ep.push_back(1'b1);
        run_frame(1, 12, bq, ep, 1'b0, "f12");

        // Reset in the middle of a frame after five pixel handshakes.
        @(negedge clk);
        sel = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b1; byte_in = 8'hA5; pixel_ready = 1'b1;
        hs_cnt = 0; guard = 0;
        while (hs_cnt < 5 && guard < 50) begin
            #1;
            if (m_pv && pixel_ready) hs_cnt++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("midreset.timeout", 0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset("midreset");
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("midreset.no_done", m_done, 0);
        end
        reset_n = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("midreset.no_done_after", m_done, 0);
        chk("midreset.idle", m_busy, 0);

        bq = {8'h01, 8'h00};
        ep.delete();
        ep.push_back(1'b1);
        for (int i = 1; i < 16; i++) ep.push_back(1'b0);
        run_frame(0, 16, bq, ep, 1'b0, "postreset");

        // Round trip: random frames packed here, unpacked by the DUT.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) pix[i] = 1'($urandom_range(0, 1));
            bq.delete();
            ep.delete();
            for (int j = 0; j < 8; j++) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++) b[k] = pix[j * 8 + k];
                bq.push_back(b);
            end
            for (int i = 0; i < 64; i++) ep.push_back(pix[i]);
            run_frame(2, 64, bq, ep, r > 0, "roundtrip");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
